sram_bank_array: RTL and testbench

SRAM_BANK_ARRAY -- requirements
Module: sram_bank_array

---
 rtl/sram_bank_array_if.sv | 33 +++
 rtl/sram_bank_array.sv | 125 ++++++++++++
 tb/tb_sram_bank_array.sv | 188 ++++++++++++++++++
 3 files changed

// File: rtl/sram_bank_array_if.sv
`default_nettype none
// ============================================================================
// Module   : sram_bank_array_if
// Brief    : Bank-array access bus: shared address, per-bank selects/enables,
//            per-column write data, per-bank read data and status outputs.
// Revision : 1.0 - initial release
// ============================================================================
interface sram_bank_array_if #(
    parameter int SRAM_BANKS_ROWS      = 1,
    parameter int SRAM_BANKS_COLS      = 1,
    parameter int SRAM_BANK_ADDR_WIDTH = 16,
    parameter int SRAM_BANK_DATA_WIDTH = 32
);
    logic [SRAM_BANK_ADDR_WIDTH-1:0]                                                bank_addr;
    logic [SRAM_BANKS_ROWS-1:0][SRAM_BANKS_COLS-1:0]                                bank_cs;
    logic [SRAM_BANKS_ROWS-1:0][SRAM_BANKS_COLS-1:0]                                bank_we;
    logic [SRAM_BANKS_ROWS-1:0][SRAM_BANKS_COLS-1:0][SRAM_BANK_DATA_WIDTH/8-1:0]    bank_be;
    logic [SRAM_BANKS_COLS-1:0][SRAM_BANK_DATA_WIDTH-1:0]                           bank_wdata;
    logic [SRAM_BANKS_ROWS-1:0][SRAM_BANKS_COLS-1:0][SRAM_BANK_DATA_WIDTH-1:0]      bank_rdata;
    logic                                                                           collision_o;
    logic [31:0]                                                                    read_count_o;

    modport master (
        output bank_addr, bank_cs, bank_we, bank_be, bank_wdata,
        input  bank_rdata, collision_o, read_count_o
    );

    modport slave (
        input  bank_addr, bank_cs, bank_we, bank_be, bank_wdata,
        output bank_rdata, collision_o, read_count_o
    );
endinterface
`default_nettype wire

// File: rtl/sram_bank_array.sv
`default_nettype none
// ============================================================================
// Module   : sram_bank_array
// Brief    : ROWS x COLS array of byte-writable SRAM banks with a configurable
//            read latency, row-collision flag and read-access counter.
//            Macro SRAM_BANK_RDATA_HOLD_EN: read data holds between reads
//            (default: read data returns to zero when no read completes).
// Revision : 1.0 - initial release
// ============================================================================
module sram_bank_array #(
    parameter int SRAM_BANKS_ROWS      = 1,
    parameter int SRAM_BANKS_COLS      = 1,
    parameter int SRAM_BANK_ADDR_WIDTH = 16,
    parameter int SRAM_BANK_DATA_WIDTH = 32,
    parameter int SRAM_READ_LATENCY    = 2
) (
    input  wire logic              clk_i,
    input  wire logic              rst_i,
    sram_bank_array_if.slave       bus
);
    localparam int c_DEPTH     = 2 ** SRAM_BANK_ADDR_WIDTH;
    localparam int c_NUM_BYTES = SRAM_BANK_DATA_WIDTH / 8;

    logic [SRAM_BANKS_ROWS-1:0][SRAM_BANKS_COLS-1:0]                           w_rd;
    logic [SRAM_BANKS_ROWS-1:0][SRAM_BANKS_COLS-1:0][SRAM_BANK_DATA_WIDTH-1:0] w_rdata;
    logic [31:0] w_rd_sum;
    logic        w_collision;
    logic        r_collision;
    logic [31:0] r_read_count;

    assign w_rd = bus.bank_cs & ~bus.bank_we;

    always_comb begin
        w_rd_sum    = '0;
        w_collision = 1'b0;
        for (int r = 0; r < SRAM_BANKS_ROWS; r++) begin
            for (int c = 0; c < SRAM_BANKS_COLS; c++) begin
                w_rd_sum = w_rd_sum + {31'b0, w_rd[r][c]};
            end
        end
        // Any pair of rows selected in the same column is a collision
        for (int c = 0; c < SRAM_BANKS_COLS; c++) begin
            for (int r1 = 0; r1 < SRAM_BANKS_ROWS; r1++) begin
                for (int r2 = r1 + 1; r2 < SRAM_BANKS_ROWS; r2++) begin
                    w_collision = w_collision | (bus.bank_cs[r1][c] & bus.bank_cs[r2][c]);
                end
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_collision  <= 1'b0;
            r_read_count <= '0;
        end else begin
            r_collision  <= w_collision;
            r_read_count <= r_read_count + w_rd_sum;
        end
    end

    assign bus.collision_o  = r_collision;
    assign bus.read_count_o = r_read_count;
    assign bus.bank_rdata   = w_rdata;

    for (genvar r = 0; r < SRAM_BANKS_ROWS; r++) begin : g_row
        for (genvar c = 0; c < SRAM_BANKS_COLS; c++) begin : g_col
            logic [SRAM_BANK_DATA_WIDTH-1:0] r_mem [c_DEPTH];
            logic [SRAM_BANK_DATA_WIDTH-1:0] w_last_data;
            logic                            w_last_vld;
            logic [SRAM_BANK_DATA_WIDTH-1:0] r_out;

            // Array contents survive reset; only accesses during reset are dropped
            always_ff @(posedge clk_i) begin
                if (!rst_i && bus.bank_cs[r][c] && bus.bank_we[r][c]) begin
                    for (int k = 0; k < c_NUM_BYTES; k++) begin
                        if (bus.bank_be[r][c][k]) begin
                            r_mem[bus.bank_addr][8*k +: 8] <= bus.bank_wdata[c][8*k +: 8];
                        end
                    end
                end
            end

            if (SRAM_READ_LATENCY == 1) begin : g_lat1
                assign w_last_data = r_mem[bus.bank_addr];
                assign w_last_vld  = w_rd[r][c];
            end else begin : g_latn
                logic [SRAM_BANK_DATA_WIDTH-1:0] r_pipe [SRAM_READ_LATENCY-1];
                logic [SRAM_READ_LATENCY-2:0]    r_vld;

                always_ff @(posedge clk_i) begin
                    if (rst_i) begin
                        r_vld <= '0;
                    end else begin
                        r_vld[0]  <= w_rd[r][c];
                        r_pipe[0] <= r_mem[bus.bank_addr];
                        for (int i = 1; i < SRAM_READ_LATENCY - 1; i++) begin
                            r_vld[i]  <= r_vld[i-1];
                            r_pipe[i] <= r_pipe[i-1];
                        end
                    end
                end

                assign w_last_data = r_pipe[SRAM_READ_LATENCY-2];
                assign w_last_vld  = r_vld[SRAM_READ_LATENCY-2];
            end

            always_ff @(posedge clk_i) begin
                if (rst_i) begin
                    r_out <= '0;
                end else begin
`ifdef SRAM_BANK_RDATA_HOLD_EN
                    if (w_last_vld) begin
                        r_out <= w_last_data;
                    end
`else
                    r_out <= w_last_vld ? w_last_data : '0;
`endif
                end
            end

            assign w_rdata[r][c] = r_out;
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_sram_bank_array.sv
`default_nettype none
// ============================================================================
// Module   : tb_sram_bank_array
// Brief    : Scoreboard bench for a 2x2 bank array with three-cycle reads.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sram_bank_array;
    localparam int ROWS = 2;
    localparam int COLS = 2;
    localparam int AW   = 8;
    localparam int DW   = 32;
    localparam int LAT  = 3;
    localparam int NB   = ROWS * COLS;
    localparam int NBY  = DW / 8;
    localparam int NA   = 32;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    sram_bank_array_if #(
        .SRAM_BANKS_ROWS(ROWS), .SRAM_BANKS_COLS(COLS),
        .SRAM_BANK_ADDR_WIDTH(AW), .SRAM_BANK_DATA_WIDTH(DW)
    ) bus ();

    sram_bank_array #(
        .SRAM_BANKS_ROWS(ROWS), .SRAM_BANKS_COLS(COLS),
        .SRAM_BANK_ADDR_WIDTH(AW), .SRAM_BANK_DATA_WIDTH(DW),
        .SRAM_READ_LATENCY(LAT)
    ) dut (
        .clk_i(clk),
        .rst_i(rst),
        .bus  (bus)
    );

    int checks = 0;
    int passed = 0;
    bit done   = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s actual=%h required=%h", name, act, exp);
    endtask

    // Reference model: plain word arrays, per-bank queues of expected read data
    logic [DW-1:0] mm [NB][NA];
    logic [DW-1:0] exp_q [NB][$];
    int            due_q [NB][$];
    logic [DW-1:0] last_val [NB];
    logic [31:0]   exp_cnt;
    logic          exp_coll;
    int            edge_n = 0;
    int            m_nrd, m_sel, m_a, m_b;
    logic [DW-1:0] m_e;

    always @(posedge clk) begin
        edge_n++;
        if (rst) begin
            for (int b = 0; b < NB; b++) begin
                exp_q[b].delete();
                due_q[b].delete();
                last_val[b] = '0;
            end
            exp_cnt  = '0;
            exp_coll = 1'b0;
        end else begin
            m_nrd    = 0;
            exp_coll = 1'b0;
            m_a      = int'(bus.bank_addr);
            for (int c = 0; c < COLS; c++) begin
                m_sel = 0;
                for (int r = 0; r < ROWS; r++) if (bus.bank_cs[r][c]) m_sel++;
                if (m_sel > 1) exp_coll = 1'b1;
            end
            for (int r = 0; r < ROWS; r++) begin
                for (int c = 0; c < COLS; c++) begin
                    m_b = r * COLS + c;
                    if (bus.bank_cs[r][c] && !bus.bank_we[r][c]) begin
                        exp_q[m_b].push_back(mm[m_b][m_a]);
                        due_q[m_b].push_back(edge_n + LAT - 1);
                        m_nrd++;
                    end
                end
            end
            for (int r = 0; r < ROWS; r++) begin
                for (int c = 0; c < COLS; c++) begin
                    m_b = r * COLS + c;
                    if (bus.bank_cs[r][c] && bus.bank_we[r][c]) begin
                        for (int k = 0; k < NBY; k++) begin
                            if (bus.bank_be[r][c][k]) mm[m_b][m_a][8*k +: 8] = bus.bank_wdata[c][8*k +: 8];
                        end
                    end
                end
            end
            exp_cnt = exp_cnt + 32'(m_nrd);
        end
    end

    // Monitor: a read due at this edge is popped, otherwise the idle value applies
    always @(negedge clk) begin
        if (edge_n > 0 && !done) begin
            for (int r = 0; r < ROWS; r++) begin
                for (int c = 0; c < COLS; c++) begin
                    m_b = r * COLS + c;
                    if (due_q[m_b].size() > 0 && due_q[m_b][0] <= edge_n) begin
                        m_e = exp_q[m_b].pop_front();
                        void'(due_q[m_b].pop_front());
                        last_val[m_b] = m_e;
                    end else begin
`ifdef SRAM_BANK_RDATA_HOLD_EN
                        m_e = last_val[m_b];
`else
                        m_e = '0;
`endif
                    end
                    check($sformatf("rdata[%0d][%0d] edge %0d", r, c, edge_n), bus.bank_rdata[r][c], m_e);
                end
            end
            check($sformatf("collision edge %0d", edge_n), {31'b0, bus.collision_o}, {31'b0, exp_coll});
            check($sformatf("read_count edge %0d", edge_n), bus.read_count_o, exp_cnt);
        end
    end

    // Bank bit index is r*COLS+c; write data for column c is wd[c*DW +: DW]
    task automatic step(input logic r, input logic [NB-1:0] cs, input logic [NB-1:0] we,
                        input logic [NB*NBY-1:0] be, input logic [AW-1:0] addr,
                        input logic [COLS*DW-1:0] wd);
        rst            = r;
        bus.bank_cs    = cs;
        bus.bank_we    = we;
        bus.bank_be    = be;
        bus.bank_addr  = addr;
        bus.bank_wdata = wd;
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, '0, '0, '0, '0, '0);
    endtask

    initial begin
        for (int i = 0; i < 3; i++) step(1'b1, '1, '0, '0, '0, '0);
        for (int a = 0; a < NA; a++) step(1'b0, '1, '1, '1, AW'(a), {$urandom, $urandom});

        step(1'b0, 4'b0001, 4'b0001, 16'h000F, 8'h10, {32'h0, 32'hDEADBEEF});
        step(1'b0, 4'b0001, 4'b0000, 16'h0000, 8'h10, '0);
        idle(LAT + 1);

        step(1'b0, 4'b0001, 4'b0001, 16'h000F, 8'd5, {32'h0, 32'hFFFFFFFF});
        step(1'b0, 4'b0001, 4'b0001, 16'h0005, 8'd5, {32'h0, 32'h00000000});
        step(1'b0, 4'b0001, 4'b0000, 16'h0000, 8'd5, '0);
        idle(LAT + 1);

        for (int a = 1; a <= 3; a++) step(1'b0, 4'b0001, 4'b0001, 16'h000F, AW'(a), {32'h0, 32'(a + 9)});
        for (int a = 1; a <= 3; a++) step(1'b0, 4'b0001, 4'b0000, 16'h0000, AW'(a), '0);
        idle(LAT + 1);

        step(1'b0, 4'b1010, 4'b0000, '0, 8'd4, '0);
        idle(1);
        step(1'b0, 4'b0011, 4'b0000, '0, 8'd4, '0);
        idle(LAT + 1);

        step(1'b0, 4'b0001, 4'b0001, 16'h000F, 8'd7, {32'h0, 32'h5A5A1234});
        step(1'b0, 4'b1111, 4'b0000, 16'hFFFF, 8'd7, '0);
        step(1'b1, 4'b1111, 4'b1111, 16'hFFFF, 8'd7, '1);
        idle(LAT + 1);
        step(1'b0, 4'b0001, 4'b0000, 16'h0000, 8'd7, '0);
        idle(LAT + 1);

        step(1'b0, 4'b0001, 4'b0001, 16'h000F, 8'd9, {32'h0, 32'h00001234});
        step(1'b0, 4'b0001, 4'b0000, 16'h0000, 8'd9, '0);
        idle(LAT + 3);

        for (int i = 0; i < 400; i++) begin
            step(($urandom_range(0, 39) == 0), NB'($urandom), NB'($urandom), (NB*NBY)'($urandom),
                 AW'($urandom_range(0, NA - 1)), {$urandom, $urandom});
        end
        idle(LAT + 3);

        #1;
        done = 1'b1;
        for (int b = 0; b < NB; b++) check($sformatf("drain bank %0d", b), 32'(due_q[b].size()), 32'd0);
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
`default_nettype wire
